// File: rtl/little_digit_pkg.sv
// Shared types and the glyph address helper for the little-digit font ROM arbiter.
package little_digit_pkg;

  localparam int CODE_W = 7;
  localparam int ADDR_W = 11;
  localparam int COL_W  = 3;

  typedef logic [ADDR_W-1:0] glyph_addr_t;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

  // Only code[6:0], row[0] and col[2:0] select a glyph bit.
  function automatic glyph_addr_t glyph_addr(input logic [CODE_W-1:0] code,
                                             input logic              row0,
                                             input logic [COL_W-1:0]  col);
    return {code, row0, col};
  endfunction

endpackage

// File: rtl/little_digit_tag_pipe.sv
// Fixed-depth shift register carrying read tags alongside the ROM access.
module little_digit_tag_pipe
  import little_digit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    clr_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  // Clearing drops every in-flight tag so no stale response survives.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/little_digit_rom_arbiter.sv
// Two-port arbiter in front of the single-port font ROM; port 0 has priority
// except when port 1 has been starved for STARVE_MAX cycles.
module little_digit_rom_arbiter
  import little_digit_pkg::*;
#(
  parameter int ROM_LAT    = 1,
  parameter int ROM_DW     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [7:0]        p0_code,
  input  logic [2:0]        p0_row,
  input  logic [10:0]       p0_col,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [ROM_DW-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic [7:0]        p1_code,
  input  logic [2:0]        p1_row,
  input  logic [10:0]       p1_col,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [ROM_DW-1:0] p1_rdata,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_DW-1:0] rom_dout
);

  localparam logic [3:0] STARVE_CAP = 4'(STARVE_MAX);

  logic [3:0]        starve_q, starve_d;
  logic              rom_en_q, rom_en_d;
  glyph_addr_t       rom_addr_q, rom_addr_d;
  logic              p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic [ROM_DW-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic              p1_win_s;
  rd_tag_t           tag_in_s, tag_out_s;
  logic              unused_s;

  assign unused_s = ^{p0_code[7], p0_row[2:1], p0_col[10:3],
                      p1_code[7], p1_row[2:1], p1_col[10:3]};

  // Arbitration, starvation tracking and next-state for the issue/return registers.
  always_comb begin
    p1_win_s = p1_req && (!p0_req || (starve_q == STARVE_CAP));
    p1_gnt   = !rst && p1_win_s;
    p0_gnt   = !rst && p0_req && !p1_win_s;

    starve_d = 4'd0;
    if (p1_req && !p1_gnt) begin
      starve_d = (starve_q == STARVE_CAP) ? starve_q : starve_q + 4'd1;
    end

    tag_in_s.valid = p0_gnt || p1_gnt;
    tag_in_s.port  = p1_gnt;

    rom_en_d   = tag_in_s.valid;
    rom_addr_d = rom_addr_q;
    if (p1_gnt) begin
      rom_addr_d = glyph_addr(p1_code[6:0], p1_row[0], p1_col[2:0]);
    end else if (p0_gnt) begin
      rom_addr_d = glyph_addr(p0_code[6:0], p0_row[0], p0_col[2:0]);
    end else begin
      rom_addr_d = rom_addr_q;
    end

    // The tag leaving the pipe lines up with rom_dout for that read.
    p0_rvalid_d = tag_out_s.valid && !tag_out_s.port;
    p1_rvalid_d = tag_out_s.valid && tag_out_s.port;
    p0_rdata_d  = p0_rvalid_d ? rom_dout : p0_rdata_q;
    p1_rdata_d  = p1_rvalid_d ? rom_dout : p1_rdata_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= 4'd0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      starve_q    <= starve_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  little_digit_tag_pipe #(.DEPTH(1 + ROM_LAT)) u_tag_pipe (
    .clk   (clk),
    .clr_i (rst),
    .tag_i (tag_in_s),
    .tag_o (tag_out_s)
  );

  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_little_digit_rom_arbiter.sv
// Bench for little_digit_rom_arbiter: ROM_LAT=1 and ROM_LAT=3 instances share stimulus,
// each fed by its own behavioural ROM and checked against an event-schedule model.
module tb_little_digit_rom_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int SMAX = 4;

  typedef struct {
    logic        rst;
    logic        q0;
    logic        q1;
    logic [7:0]  c0;
    logic [2:0]  r0;
    logic [10:0] k0;
    logic [7:0]  c1;
    logic [2:0]  r1;
    logic [10:0] k1;
    logic        ck;
    logic        eg0;
    logic        eg1;
  } vec_t;

  logic clk = 1'b0;
  logic rst, p0_req, p1_req;
  logic [7:0] p0_code, p1_code;
  logic [2:0] p0_row, p1_row;
  logic [10:0] p0_col, p1_col;

  logic [1:0] p0_gnt_w, p1_gnt_w, p0_rv_w, p1_rv_w, rom_en_w;
  logic [1:0][10:0] rom_addr_w;
  logic [1:0][7:0] p0_rd_w, p1_rd_w, rom_dout_w;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;
  bit armed    = 1'b0;

  int          starve_m;
  logic        en_m;
  logic [10:0] addr_m;
  bit          ev_v [2][16];
  bit          ev_p [2][16];
  logic [7:0]  ev_d [2][16];
  logic [7:0]  last_d [2][2];
  int          rv0_seen [2];
  int          first_rv [2];

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'h5A;
  endfunction

  logic [7:0] rp1;
  logic [7:0] rp3 [3];
  always_ff @(posedge clk) begin
    rp1    <= rom_fn(rom_addr_w[0]);
    rp3[0] <= rom_fn(rom_addr_w[1]);
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign rom_dout_w[0] = rp1;
  assign rom_dout_w[1] = rp3[2];

  little_digit_rom_arbiter #(.ROM_LAT(LAT0), .ROM_DW(8), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_code(p0_code), .p0_row(p0_row), .p0_col(p0_col),
    .p0_gnt(p0_gnt_w[0]), .p0_rvalid(p0_rv_w[0]), .p0_rdata(p0_rd_w[0]),
    .p1_req(p1_req), .p1_code(p1_code), .p1_row(p1_row), .p1_col(p1_col),
    .p1_gnt(p1_gnt_w[0]), .p1_rvalid(p1_rv_w[0]), .p1_rdata(p1_rd_w[0]),
    .rom_en(rom_en_w[0]), .rom_addr(rom_addr_w[0]), .rom_dout(rom_dout_w[0]));

  little_digit_rom_arbiter #(.ROM_LAT(LAT1), .ROM_DW(8), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_code(p0_code), .p0_row(p0_row), .p0_col(p0_col),
    .p0_gnt(p0_gnt_w[1]), .p0_rvalid(p0_rv_w[1]), .p0_rdata(p0_rd_w[1]),
    .p1_req(p1_req), .p1_code(p1_code), .p1_row(p1_row), .p1_col(p1_col),
    .p1_gnt(p1_gnt_w[1]), .p1_rvalid(p1_rv_w[1]), .p1_rdata(p1_rd_w[1]),
    .rom_en(rom_en_w[1]), .rom_addr(rom_addr_w[1]), .rom_dout(rom_dout_w[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  function automatic vec_t mk(input logic r, input logic q0, input logic q1,
                              input logic [7:0] c0, input logic [2:0] r0, input logic [10:0] k0,
                              input logic [7:0] c1, input logic [2:0] r1, input logic [10:0] k1,
                              input logic ck, input logic eg0, input logic eg1);
    vec_t v;
    v.rst = r; v.q0 = q0; v.q1 = q1;
    v.c0 = c0; v.r0 = r0; v.k0 = k0;
    v.c1 = c1; v.r1 = r1; v.k1 = k1;
    v.ck = ck; v.eg0 = eg0; v.eg1 = eg1;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 11'd0, 8'd0, 3'd0, 11'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [10:0] addr_of(input logic [7:0] c, input logic [2:0] r, input logic [10:0] k);
    int a;
    a = (int'(c) % 128) * 16 + (int'(r) % 2) * 8 + (int'(k) % 8);
    return a[10:0];
  endfunction

  task automatic check_regs();
    int s;
    bit e0, e1;
    s = cyc % 16;
    for (int i = 0; i < 2; i++) begin
      e0 = ev_v[i][s] && !ev_p[i][s];
      e1 = ev_v[i][s] && ev_p[i][s];
      if (e0) last_d[i][0] = ev_d[i][s];
      if (e1) last_d[i][1] = ev_d[i][s];
      ev_v[i][s] = 1'b0;
      chk($sformatf("i%0d rom_en", i), 32'(rom_en_w[i]), 32'(en_m));
      chk($sformatf("i%0d rom_addr", i), 32'(rom_addr_w[i]), 32'(addr_m));
      chk($sformatf("i%0d p0_rvalid", i), 32'(p0_rv_w[i]), 32'(e0));
      chk($sformatf("i%0d p1_rvalid", i), 32'(p1_rv_w[i]), 32'(e1));
      chk($sformatf("i%0d p0_rdata", i), 32'(p0_rd_w[i]), 32'(last_d[i][0]));
      chk($sformatf("i%0d p1_rdata", i), 32'(p1_rd_w[i]), 32'(last_d[i][1]));
      if (p0_rv_w[i] === 1'b1) begin
        rv0_seen[i]++;
        if (first_rv[i] < 0) first_rv[i] = cyc;
      end
    end
  endtask

  task automatic step(input vec_t v);
    bit g0, g1;
    logic [10:0] a;
    int lat;
    @(posedge clk);
    #1;
    cyc++;
    if (armed) check_regs();
    rst = v.rst; p0_req = v.q0; p1_req = v.q1;
    p0_code = v.c0; p0_row = v.r0; p0_col = v.k0;
    p1_code = v.c1; p1_row = v.r1; p1_col = v.k1;
    #1;
    g1 = !v.rst && v.q1 && (!v.q0 || starve_m == SMAX);
    g0 = !v.rst && v.q0 && !g1;
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("i%0d p0_gnt", i), 32'(p0_gnt_w[i]), 32'(g0));
        chk($sformatf("i%0d p1_gnt", i), 32'(p1_gnt_w[i]), 32'(g1));
      end
    end
    if (v.ck) begin
      chk("table p0_gnt", 32'(p0_gnt_w[0]), 32'(v.eg0));
      chk("table p1_gnt", 32'(p1_gnt_w[0]), 32'(v.eg1));
    end
    if (v.rst) begin
      starve_m = 0; en_m = 1'b0; addr_m = 11'd0;
      for (int i = 0; i < 2; i++) begin
        for (int s = 0; s < 16; s++) ev_v[i][s] = 1'b0;
        last_d[i][0] = 8'd0; last_d[i][1] = 8'd0;
      end
      armed = 1'b1;
    end else begin
      en_m = g0 || g1;
      if (g0 || g1) begin
        a = g1 ? addr_of(v.c1, v.r1, v.k1) : addr_of(v.c0, v.r0, v.k0);
        addr_m = a;
        for (int i = 0; i < 2; i++) begin
          lat = (i == 0) ? LAT0 : LAT1;
          ev_v[i][(cyc + 2 + lat) % 16] = 1'b1;
          ev_p[i][(cyc + 2 + lat) % 16] = g1;
          ev_d[i][(cyc + 2 + lat) % 16] = rom_fn(a);
        end
      end
      if (v.q1 && !g1) starve_m = (starve_m + 1 > SMAX) ? SMAX : starve_m + 1;
      else starve_m = 0;
    end
  endtask

  vec_t tbl[$];
  vec_t rv;
  int   gcyc;
  int   seen_before;

  initial begin
    rst = 1'b1; p0_req = 1'b0; p1_req = 1'b0;
    p0_code = 8'd0; p0_row = 3'd0; p0_col = 11'd0;
    p1_code = 8'd0; p1_row = 3'd0; p1_col = 11'd0;
    starve_m = 0; en_m = 1'b0; addr_m = 11'd0;
    for (int i = 0; i < 2; i++) begin rv0_seen[i] = 0; first_rv[i] = -1; end

    for (int n = 0; n < 4; n++)
      step(mk(1'b1, 1'b0, 1'b0, 8'd0, 3'd0, 11'd0, 8'd0, 3'd0, 11'd0, 1'b0, 1'b0, 1'b0));

    // Table: contention (4:1 pattern), then p1 streaming addresses 0..7.
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 11'd0, 8'd0, 3'd0, 11'd0, 1'b1, 1'b0, 1'b0));
    for (int n = 0; n < 10; n++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'(8'h20 + n), 3'(n), 11'(n), 8'(8'h40 + n), 3'(n + 1), 11'(7 - n),
                       1'b1, (n % 5) != 4, (n % 5) == 4));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 11'd0, 8'd0, 3'd0, 11'd0, 1'b1, 1'b0, 1'b0));
    for (int n = 0; n < 8; n++)
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'd0, 3'd0, 11'd0, 8'd0, 3'd0, 11'(n), 1'b1, 1'b0, 1'b1));
    for (int n = 0; n < 6; n++) tbl.push_back(idle());
    foreach (tbl[n]) step(tbl[n]);

    // Solo p0 latency on both builds: code 0x35, row 1, col 6.
    for (int i = 0; i < 2; i++) first_rv[i] = -1;
    step(mk(1'b0, 1'b1, 1'b0, 8'h35, 3'd1, 11'd6, 8'd0, 3'd0, 11'd0, 1'b1, 1'b1, 1'b0));
    gcyc = cyc;
    step(idle());
    chk("solo rom_addr", 32'(rom_addr_w[0]), 32'h35E);
    for (int n = 0; n < 7; n++) step(idle());
    chk("latency lat1", 32'(first_rv[0] - gcyc), 32'(2 + LAT0));
    chk("latency lat3", 32'(first_rv[1] - gcyc), 32'(2 + LAT1));

    // Reset one cycle after a p0 grant: the read must vanish.
    seen_before = rv0_seen[0];
    step(mk(1'b0, 1'b1, 1'b0, 8'h12, 3'd0, 11'd2, 8'd0, 3'd0, 11'd0, 1'b1, 1'b1, 1'b0));
    step(mk(1'b1, 1'b1, 1'b1, 8'h12, 3'd0, 11'd2, 8'h13, 3'd0, 11'd2, 1'b1, 1'b0, 1'b0));
    step(idle());
    chk("post-rst rom_en", 32'(rom_en_w[0]), 32'd0);
    chk("post-rst rom_addr", 32'(rom_addr_w[0]), 32'd0);
    chk("post-rst rvalid", 32'({p0_rv_w[0], p1_rv_w[0]}), 32'd0);
    chk("post-rst rdata", 32'({p0_rd_w[0], p1_rd_w[0]}), 32'd0);
    for (int n = 0; n < 6; n++) step(idle());
    chk("rst drops read", 32'(rv0_seen[0] - seen_before), 32'd0);

    // Code bit 7 is ignored.
    step(mk(1'b0, 1'b1, 1'b0, 8'h85, 3'd2, 11'd3, 8'd0, 3'd0, 11'd0, 1'b1, 1'b1, 1'b0));
    step(idle());
    chk("code 0x85 addr", 32'(rom_addr_w[0]), 32'h053);
    step(mk(1'b0, 1'b1, 1'b0, 8'h05, 3'd2, 11'd3, 8'd0, 3'd0, 11'd0, 1'b1, 1'b1, 1'b0));
    step(idle());
    chk("code 0x05 addr", 32'(rom_addr_w[0]), 32'h053);
    for (int n = 0; n < 6; n++) step(idle());

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      rv = mk($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              8'($urandom), 3'($urandom), 11'($urandom), 8'($urandom), 3'($urandom), 11'($urandom),
              1'b0, 1'b0, 1'b0);
      step(rv);
    end
    for (int n = 0; n < 8; n++) step(idle());

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
